// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: FWFT elastic buffer behind uart_rx with sticky overflow and saturating parity-error count
module uart_rx_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter bit DROP_BAD_PARITY = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_vld,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic                        i_pc_pass,
  output logic                        o_rdy,
  output logic                        o_vld,
  output logic [DATA_WIDTH-1:0]       o_data,
  output logic                        o_pc_pass,
  input  logic                        i_rdy,
  output logic [$clog2(DEPTH):0]      o_count,
  output logic                        o_overflow,
  input  logic                        i_clr,
  output logic [7:0]                  o_err_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH:0] head;
  logic wr_en, rd_en, drop, perr;
  assign o_count = wr_ptr - rd_ptr;
  assign o_vld = wr_ptr != rd_ptr;
  assign o_rdy = !(wr_ptr[AW-1:0] == rd_ptr[AW-1:0] && wr_ptr[AW] != rd_ptr[AW]);
  assign wr_en = i_vld && o_rdy && !(DROP_BAD_PARITY && !i_pc_pass);
  assign rd_en = o_vld && i_rdy;
  assign drop = i_vld && !o_rdy;
  assign perr = i_vld && !i_pc_pass;
  // gated so the head reads as zero out of reset even though the array is not reset
  assign head = o_vld ? mem[rd_ptr[AW-1:0]] : '0;
  assign o_data = head[DATA_WIDTH-1:0];
  assign o_pc_pass = head[DATA_WIDTH];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {i_pc_pass, i_data};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_overflow <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      o_overflow <= drop ? 1'b1 : i_clr ? 1'b0 : o_overflow;
      o_err_cnt <= perr ? (i_clr ? 8'd1 : (&o_err_cnt) ? o_err_cnt : o_err_cnt + 8'd1)
                        : (i_clr ? 8'd0 : o_err_cnt);
    end
  end
endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: queue-model scoreboard plus directed checks for both parity-drop settings
module tb_uart_rx_buffer;
  logic clk = 0, rst = 0;
  logic i_vld = 0, i_pc_pass = 0, i_rdy = 0, i_clr = 0;
  logic [7:0] i_data = 0;
  logic o_rdy0, o_vld0, o_pc_pass0, o_overflow0, o_rdy1, o_vld1, o_pc_pass1, o_overflow1;
  logic [7:0] o_data0, o_data1, o_err_cnt0, o_err_cnt1;
  logic [4:0] o_count0, o_count1;
  int checks = 0, errors = 0, wr0 = 0;
  logic [8:0] q [2][$];
  logic movf [2] = '{1'b0, 1'b0};
  int merr = 0;

  uart_rx_buffer #(.DATA_WIDTH(8), .DEPTH(16), .DROP_BAD_PARITY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_data(i_data), .i_pc_pass(i_pc_pass),
    .o_rdy(o_rdy0), .o_vld(o_vld0), .o_data(o_data0), .o_pc_pass(o_pc_pass0), .i_rdy(i_rdy),
    .o_count(o_count0), .o_overflow(o_overflow0), .i_clr(i_clr), .o_err_cnt(o_err_cnt0));
  uart_rx_buffer #(.DATA_WIDTH(8), .DEPTH(16), .DROP_BAD_PARITY(1'b1)) dut1 (
    .clk(clk), .rst(rst), .i_vld(i_vld), .i_data(i_data), .i_pc_pass(i_pc_pass),
    .o_rdy(o_rdy1), .o_vld(o_vld1), .o_data(o_data1), .o_pc_pass(o_pc_pass1), .i_rdy(i_rdy),
    .o_count(o_count1), .o_overflow(o_overflow1), .i_clr(i_clr), .o_err_cnt(o_err_cnt1));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // FIFO semantics as queues: a full FIFO drops, a read frees no slot for the same-edge write
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q[0].delete(); q[1].delete();
      movf[0] = 0; movf[1] = 0; merr = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        automatic bit full = q[k].size() == 16;
        if (q[k].size() > 0 && i_rdy) void'(q[k].pop_front());
        if (i_vld && !full && !(k == 1 && !i_pc_pass)) begin
          q[k].push_back({i_pc_pass, i_data});
          if (k == 0) wr0++;
        end
        if (i_vld && full) movf[k] = 1;
        else if (i_clr) movf[k] = 0;
      end
      if (i_vld && !i_pc_pass) merr = i_clr ? 1 : (merr == 255 ? 255 : merr + 1);
      else if (i_clr) merr = 0;
    end
  end

  always @(negedge clk) begin
    chk("vld0", o_vld0, q[0].size() != 0);
    chk("cnt0", o_count0, q[0].size());
    chk("rdy0", o_rdy0, q[0].size() < 16);
    chk("ovf0", o_overflow0, movf[0]);
    chk("err0", o_err_cnt0, merr);
    if (q[0].size() != 0) chk("head0", {o_pc_pass0, o_data0}, q[0][0]);
    chk("vld1", o_vld1, q[1].size() != 0);
    chk("cnt1", o_count1, q[1].size());
    chk("rdy1", o_rdy1, q[1].size() < 16);
    chk("ovf1", o_overflow1, movf[1]);
    chk("err1", o_err_cnt1, merr);
    if (q[1].size() != 0) chk("head1", {o_pc_pass1, o_data1}, q[1][0]);
  end

  task automatic step(input logic v, input logic [7:0] d, input logic p, input logic r, input logic c);
    i_vld = v; i_data = d; i_pc_pass = p; i_rdy = r; i_clr = c;
    @(posedge clk); #1;
    i_vld = 0; i_rdy = 0; i_clr = 0;
  endtask

  initial begin
    #1;
    chk("rst_vld", o_vld0, 0); chk("rst_rdy", o_rdy0, 1); chk("rst_cnt", o_count0, 0);
    chk("rst_data", o_data0, 0); chk("rst_pc", o_pc_pass0, 0);
    chk("rst_ovf", o_overflow0, 0); chk("rst_err", o_err_cnt0, 0);
    #11 rst = 1;
    // single word
    step(1, 8'h5A, 1, 0, 0);
    chk("sw_vld", o_vld0, 1); chk("sw_data", o_data0, 8'h5A);
    chk("sw_pc", o_pc_pass0, 1); chk("sw_cnt", o_count0, 1);
    step(0, 0, 0, 1, 0);
    chk("sw_cnt_after", o_count0, 0); chk("sw_vld_after", o_vld0, 0);
    // fill, overflow, full with simultaneous read
    for (int i = 0; i < 16; i++) step(1, 8'(i), 1, 0, 0);
    chk("fill_rdy", o_rdy0, 0); chk("fill_cnt", o_count0, 16);
    step(1, 8'h10, 1, 0, 0);
    chk("ovf_cnt", o_count0, 16); chk("ovf_flag", o_overflow0, 1);
    chk("full_head", o_data0, 8'h00);
    step(1, 8'h11, 1, 1, 0);
    chk("full_rd_cnt", o_count0, 15); chk("full_rd_rdy", o_rdy0, 1);
    for (int i = 1; i < 16; i++) begin
      chk("drain", o_data0, i);
      step(0, 0, 0, 1, 0);
    end
    chk("drain_empty", o_vld0, 0);
    // parity handling
    for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), 0, 0, 0);
    chk("par_cnt0", o_count0, 3); chk("par_pc0", o_pc_pass0, 0);
    chk("par_err0", o_err_cnt0, 3); chk("par_cnt1", o_count1, 0); chk("par_err1", o_err_cnt1, 3);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    // saturation and clear
    for (int i = 0; i < 300; i++) step(1, 8'(i), 0, 1, 0);
    chk("sat", o_err_cnt0, 255); chk("ovf_still", o_overflow0, 1);
    step(0, 0, 1, 0, 1);
    chk("clr_err", o_err_cnt0, 0); chk("clr_ovf", o_overflow0, 0);
    step(1, 8'h33, 0, 1, 1);
    chk("clr_bad", o_err_cnt0, 1);
    step(0, 0, 0, 1, 0);
    // async reset mid-burst
    for (int i = 0; i < 7; i++) step(1, 8'(8'h70 + i), 1, 0, 0);
    chk("pre_rst_cnt", o_count0, 7);
    #2 rst = 0;
    #1;
    chk("ar_vld", o_vld0, 0); chk("ar_cnt", o_count0, 0); chk("ar_rdy", o_rdy0, 1);
    rst = 1;
    step(1, 8'hA5, 1, 0, 0);
    chk("ar_first", o_data0, 8'hA5); chk("ar_first_cnt", o_count0, 1);
    step(0, 0, 0, 1, 0);
    // random streaming
    wr0 = 0;
    for (int n = 0; n < 25000; n++) begin
      i_vld = 1'($urandom); i_data = 8'($urandom); i_pc_pass = ($urandom % 8) != 0;
      i_rdy = 1'($urandom); i_clr = ($urandom % 512) == 0;
      @(posedge clk); #1;
    end
    i_vld = 0; i_rdy = 0; i_clr = 0;
    chk("wraps", wr0 / 16 > 600, 1);
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
